// File: rtl/bpi_flash_seq_if.sv
// Bundle of the command ports, the auto-load ports and the flash pad signals
// seen by the BPI flash sequencer.
interface bpi_flash_seq_if #(
  parameter int AW = 23,
  parameter int DW = 16,
  parameter int CW = 8
);
  // user command source
  logic [AW-1:0] ADDR;
  logic [DW-1:0] CMD_DATA_OUT;
  logic [1:0]    OP;
  logic [CW-1:0] RD_WORDS;
  logic          EXECUTE;
  // auto-load command source
  logic          AUTO_LOAD_ENA;
  logic [AW-1:0] AL_ADDR;
  logic [DW-1:0] AL_CMD_DATA_OUT;
  logic [1:0]    AL_OP;
  logic [CW-1:0] AL_RD_WORDS;
  logic          AL_EXECUTE;
  // pad side and results
  logic [DW-1:0] FLASH_D_IN;
  logic [DW-1:0] DATA_IN;
  logic          LOAD_DATA;
  logic          BUSY;
  logic [AW-1:0] FLASH_A;
  logic [DW-1:0] FLASH_D_OUT;
  logic          FLASH_D_OE;
  logic          FCS_B;
  logic          FOE_B;
  logic          FWE_B;
  logic          FLATCH_B;

  // command/pad side that drives the sequencer
  modport master (
    output ADDR, CMD_DATA_OUT, OP, RD_WORDS, EXECUTE,
    output AUTO_LOAD_ENA, AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_RD_WORDS, AL_EXECUTE,
    output FLASH_D_IN,
    input  DATA_IN, LOAD_DATA, BUSY, FLASH_A, FLASH_D_OUT, FLASH_D_OE,
    input  FCS_B, FOE_B, FWE_B, FLATCH_B
  );

  // the sequencer itself
  modport slave (
    input  ADDR, CMD_DATA_OUT, OP, RD_WORDS, EXECUTE,
    input  AUTO_LOAD_ENA, AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_RD_WORDS, AL_EXECUTE,
    input  FLASH_D_IN,
    output DATA_IN, LOAD_DATA, BUSY, FLASH_A, FLASH_D_OUT, FLASH_D_OE,
    output FCS_B, FOE_B, FWE_B, FLATCH_B
  );
endinterface

// File: rtl/bpi_flash_seq.sv
// BPI parallel NOR flash bus sequencer: single-word writes and burst reads
// with parameterised phase timing, arbitrating between a user and an
// auto-load command source. Every output comes straight from a flop; the
// control flops are loaded from the decoded next state so they line up with
// the state the machine is entering.
module bpi_flash_seq #(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int CW      = 8,
  parameter int T_LATCH = 2,
  parameter int T_WE    = 3,
  parameter int T_OE    = 4,
  parameter int T_REC   = 2
) (
  input logic         CLK,
  input logic         RST,
  bpi_flash_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_ACCESS,
    S_RECOVER
  } state_t;

  localparam int TMAX1 = (T_LATCH > T_WE) ? T_LATCH : T_WE;
  localparam int TMAX2 = (T_OE > T_REC) ? T_OE : T_REC;
  localparam int TMAX  = (TMAX1 > TMAX2) ? TMAX1 : TMAX2;
  localparam int PW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(T_LATCH - 1);
  localparam logic [PW-1:0] WE_LAST    = PW'(T_WE - 1);
  localparam logic [PW-1:0] OE_LAST    = PW'(T_OE - 1);
  localparam logic [PW-1:0] REC_LAST   = PW'(T_REC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] words_q, words_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          is_read_q, is_read_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          d_oe_q, d_oe_d;
  logic          fcs_b_q, fcs_b_d;
  logic          foe_b_q, foe_b_d;
  logic          fwe_b_q, fwe_b_d;
  logic          flatch_b_q, flatch_b_d;

  logic          sel_exec;
  logic [1:0]    sel_op;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [CW-1:0] sel_words;

  // Pick the command source; the strobe of the other source is ignored.
  always_comb begin
    sel_exec  = bus.EXECUTE;
    sel_op    = bus.OP;
    sel_addr  = bus.ADDR;
    sel_data  = bus.CMD_DATA_OUT;
    sel_words = bus.RD_WORDS;
    if (bus.AUTO_LOAD_ENA) begin
      sel_exec  = bus.AL_EXECUTE;
      sel_op    = bus.AL_OP;
      sel_addr  = bus.AL_ADDR;
      sel_data  = bus.AL_CMD_DATA_OUT;
      sel_words = bus.AL_RD_WORDS;
    end
  end

  // Phase sequencing plus decode of the pad controls for the next state.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    words_d   = words_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    data_in_d = data_in_q;
    load_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_exec && (sel_op == 2'b01 || sel_op == 2'b10)) begin
          state_d   = S_LATCH;
          phase_d   = '0;
          addr_d    = sel_addr;
          wdata_d   = sel_data;
          is_read_d = (sel_op == 2'b10);
          words_d   = (sel_words == '0) ? CW'(1) : sel_words;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          phase_d = '0;
          state_d = is_read_q ? S_RD_ACCESS : S_WR_PULSE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_WR_PULSE: begin
        if (phase_q == WE_LAST) begin
          phase_d = '0;
          state_d = S_WR_HOLD;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_WR_HOLD: begin
        phase_d = '0;
        state_d = S_RECOVER;
      end
      S_RD_ACCESS: begin
        if (phase_q == OE_LAST) begin
          phase_d   = '0;
          data_in_d = bus.FLASH_D_IN;
          load_d    = 1'b1;
          words_d   = words_q - CW'(1);
          if (words_q > CW'(1)) begin
            addr_d  = addr_q + AW'(1);
            state_d = S_LATCH;
          end else begin
            state_d = S_RECOVER;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_RECOVER: begin
        if (phase_q == REC_LAST) begin
          phase_d = '0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    fcs_b_d    = !(state_d == S_LATCH || state_d == S_WR_PULSE ||
                   state_d == S_WR_HOLD || state_d == S_RD_ACCESS);
    flatch_b_d = (state_d != S_LATCH);
    fwe_b_d    = (state_d != S_WR_PULSE);
    foe_b_d    = (state_d != S_RD_ACCESS);
    d_oe_d     = (state_d == S_LATCH && !is_read_d) ||
                 state_d == S_WR_PULSE || state_d == S_WR_HOLD;
  end

  // State and output registers; reset abandons any operation immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_read_q  <= 1'b0;
      data_in_q  <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      d_oe_q     <= 1'b0;
      fcs_b_q    <= 1'b1;
      foe_b_q    <= 1'b1;
      fwe_b_q    <= 1'b1;
      flatch_b_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_read_q  <= is_read_d;
      data_in_q  <= data_in_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      d_oe_q     <= d_oe_d;
      fcs_b_q    <= fcs_b_d;
      foe_b_q    <= foe_b_d;
      fwe_b_q    <= fwe_b_d;
      flatch_b_q <= flatch_b_d;
    end
  end

  assign bus.DATA_IN     = data_in_q;
  assign bus.LOAD_DATA   = load_q;
  assign bus.BUSY        = busy_q;
  assign bus.FLASH_A     = addr_q;
  assign bus.FLASH_D_OUT = wdata_q;
  assign bus.FLASH_D_OE  = d_oe_q;
  assign bus.FCS_B       = fcs_b_q;
  assign bus.FOE_B       = foe_b_q;
  assign bus.FWE_B       = fwe_b_q;
  assign bus.FLATCH_B    = flatch_b_q;

endmodule

// File: tb/tb_bpi_flash_seq.sv
// Scoreboard bench for bpi_flash_seq: a default-timing instance (a) and a
// minimum-timing, 26-bit address instance (b) share one clock.
module tb_bpi_flash_seq;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  bpi_flash_seq_if #(.AW(23), .DW(16), .CW(8)) bus_a ();
  bpi_flash_seq_if #(.AW(26), .DW(16), .CW(8)) bus_b ();

  bpi_flash_seq dut_a (.CLK(clk), .RST(rst_a), .bus(bus_a.slave));
  bpi_flash_seq #(.AW(26), .DW(16), .CW(8), .T_LATCH(1), .T_WE(1), .T_OE(1), .T_REC(1))
    dut_b (.CLK(clk), .RST(rst_b), .bus(bus_b.slave));

  // flash model: address 0x10 holds 0x1234, elsewhere data = address low bits
  assign bus_a.FLASH_D_IN = bus_a.FOE_B ? 16'hDEAD :
                            ((bus_a.FLASH_A == 23'h10) ? 16'h1234 : bus_a.FLASH_A[15:0]);
  assign bus_b.FLASH_D_IN = bus_b.FOE_B ? 16'hDEAD :
                            ((bus_b.FLASH_A == 26'h10) ? 16'h1234 : bus_b.FLASH_A[15:0]);

  int compares = 0;
  int fails    = 0;
  int writes_a = 0;
  int viol     = 0;
  int run_a    = 0;
  int run_b    = 0;
  logic prev_latch_a = 1'b1;
  logic prev_we_a    = 1'b1;

  logic [31:0] exp_data_a[$], exp_busy_a[$], exp_addr_a[$], exp_waddr_a[$], exp_wdata_a[$];
  logic [31:0] exp_data_b[$], exp_busy_b[$];

  logic [31:0] busy_m, latch_m, we_m, oe_m, doe_m, cs_m, load_m;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for instance a: read data, latched addresses, writes, busy length.
  always @(negedge clk) begin
    if (bus_a.LOAD_DATA) begin
      if (exp_data_a.size() == 0) checkOutput("load_a_expected", 32'(exp_data_a.size()), 32'd1);
      else checkOutput("data_a", 32'(bus_a.DATA_IN), exp_data_a.pop_front());
    end
    if (!bus_a.FLATCH_B && prev_latch_a) begin
      if (exp_addr_a.size() == 0) checkOutput("latch_a_expected", 32'(exp_addr_a.size()), 32'd1);
      else checkOutput("flash_a", 32'(bus_a.FLASH_A), exp_addr_a.pop_front());
    end
    if (bus_a.FWE_B && !prev_we_a) begin
      writes_a++;
      if (exp_waddr_a.size() == 0) checkOutput("write_a_expected", 32'(exp_waddr_a.size()), 32'd1);
      else begin
        checkOutput("write_addr_a", 32'(bus_a.FLASH_A), exp_waddr_a.pop_front());
        checkOutput("write_data_a", 32'(bus_a.FLASH_D_OUT), exp_wdata_a.pop_front());
      end
    end
    if (bus_a.BUSY) run_a++;
    else if (run_a > 0) begin
      if (exp_busy_a.size() == 0) checkOutput("busy_a_expected", 32'(exp_busy_a.size()), 32'd1);
      else checkOutput("busy_len_a", 32'(run_a), exp_busy_a.pop_front());
      run_a = 0;
    end
    if ((bus_a.FLASH_D_OE && !bus_a.FOE_B) ||
        (!bus_a.FLATCH_B && (!bus_a.FWE_B || !bus_a.FOE_B))) viol++;
    prev_latch_a = bus_a.FLATCH_B;
    prev_we_a    = bus_a.FWE_B;
  end

  // Monitor for instance b: read data, busy length, bus rules.
  always @(negedge clk) begin
    if (bus_b.LOAD_DATA) begin
      if (exp_data_b.size() == 0) checkOutput("load_b_expected", 32'(exp_data_b.size()), 32'd1);
      else checkOutput("data_b", 32'(bus_b.DATA_IN), exp_data_b.pop_front());
    end
    if (bus_b.BUSY) run_b++;
    else if (run_b > 0) begin
      if (exp_busy_b.size() == 0) checkOutput("busy_b_expected", 32'(exp_busy_b.size()), 32'd1);
      else checkOutput("busy_len_b", 32'(run_b), exp_busy_b.pop_front());
      run_b = 0;
    end
    if ((bus_b.FLASH_D_OE && !bus_b.FOE_B) ||
        (!bus_b.FLATCH_B && (!bus_b.FWE_B || !bus_b.FOE_B))) viol++;
  end

  // Drive one command strobe; returns 1 time unit after the acceptance edge.
  task automatic applyStimulus(input int sel, input bit al, input logic [1:0] op,
                               input logic [31:0] addr, input logic [15:0] data,
                               input logic [7:0] words);
    @(negedge clk);
    if (sel == 0) begin
      bus_a.AUTO_LOAD_ENA = al;
      if (al) begin
        bus_a.AL_OP = op; bus_a.AL_ADDR = addr[22:0]; bus_a.AL_CMD_DATA_OUT = data;
        bus_a.AL_RD_WORDS = words; bus_a.AL_EXECUTE = 1'b1;
      end else begin
        bus_a.OP = op; bus_a.ADDR = addr[22:0]; bus_a.CMD_DATA_OUT = data;
        bus_a.RD_WORDS = words; bus_a.EXECUTE = 1'b1;
      end
    end else begin
      bus_b.OP = op; bus_b.ADDR = addr[25:0]; bus_b.CMD_DATA_OUT = data;
      bus_b.RD_WORDS = words; bus_b.EXECUTE = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_a.EXECUTE = 1'b0; bus_a.AL_EXECUTE = 1'b0; bus_b.EXECUTE = 1'b0;
  endtask

  // Capture cycles 1..n after acceptance as bit masks (1 = signal active).
  task automatic recordTrace(input int sel, input int n);
    busy_m = '0; latch_m = '0; we_m = '0; oe_m = '0; doe_m = '0; cs_m = '0; load_m = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        busy_m[k] = bus_a.BUSY; latch_m[k] = !bus_a.FLATCH_B; we_m[k] = !bus_a.FWE_B;
        oe_m[k] = !bus_a.FOE_B; doe_m[k] = bus_a.FLASH_D_OE; cs_m[k] = !bus_a.FCS_B;
        load_m[k] = bus_a.LOAD_DATA;
      end else begin
        busy_m[k] = bus_b.BUSY; latch_m[k] = !bus_b.FLATCH_B; we_m[k] = !bus_b.FWE_B;
        oe_m[k] = !bus_b.FOE_B; doe_m[k] = bus_b.FLASH_D_OE; cs_m[k] = !bus_b.FCS_B;
        load_m[k] = bus_b.LOAD_DATA;
      end
    end
  endtask

  task automatic waitIdle(input int sel);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 300 && b; i++) begin
      @(negedge clk);
      b = (sel == 0) ? bus_a.BUSY : bus_b.BUSY;
    end
    checkOutput("idle_timeout", 32'(b), 32'd0);
  endtask

  int wr_before;

  initial begin
    bus_a.ADDR = '0; bus_a.CMD_DATA_OUT = '0; bus_a.OP = '0; bus_a.RD_WORDS = '0;
    bus_a.EXECUTE = 0; bus_a.AUTO_LOAD_ENA = 0; bus_a.AL_ADDR = '0; bus_a.AL_CMD_DATA_OUT = '0;
    bus_a.AL_OP = '0; bus_a.AL_RD_WORDS = '0; bus_a.AL_EXECUTE = 0;
    bus_b.ADDR = '0; bus_b.CMD_DATA_OUT = '0; bus_b.OP = '0; bus_b.RD_WORDS = '0;
    bus_b.EXECUTE = 0; bus_b.AUTO_LOAD_ENA = 0; bus_b.AL_ADDR = '0; bus_b.AL_CMD_DATA_OUT = '0;
    bus_b.AL_OP = '0; bus_b.AL_RD_WORDS = '0; bus_b.AL_EXECUTE = 0;
    rst_a = 1'b1; rst_b = 1'b1;

    // reset state, with a write strobe presented during reset
    repeat (3) @(negedge clk);
    bus_a.OP = 2'b01; bus_a.ADDR = 23'h77; bus_a.EXECUTE = 1'b1;
    @(negedge clk);
    checkOutput("reset_ctrl_a", 32'({bus_a.BUSY, bus_a.LOAD_DATA, bus_a.FLASH_D_OE, bus_a.FCS_B,
                                     bus_a.FOE_B, bus_a.FWE_B, bus_a.FLATCH_B}), 32'h0F);
    checkOutput("reset_flash_a", 32'(bus_a.FLASH_A), 32'h0);
    checkOutput("reset_d_out", 32'(bus_a.FLASH_D_OUT), 32'h0);
    checkOutput("reset_data_in", 32'(bus_a.DATA_IN), 32'h0);
    bus_a.EXECUTE = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("exec_in_reset_ignored", 32'(bus_a.BUSY), 32'd0);

    $display("[TB] single-word write");
    exp_busy_a.push_back(8); exp_addr_a.push_back(32'h155);
    exp_waddr_a.push_back(32'h155); exp_wdata_a.push_back(32'hAA);
    applyStimulus(0, 0, 2'b01, 32'h155, 16'h00AA, 8'd0);
    recordTrace(0, 10);
    checkOutput("wr_busy", busy_m, 32'hFF);
    checkOutput("wr_latch", latch_m, 32'h3);
    checkOutput("wr_we", we_m, 32'h1C);
    checkOutput("wr_doe", doe_m, 32'h3F);
    checkOutput("wr_cs", cs_m, 32'h3F);
    checkOutput("wr_oe", oe_m, 32'h0);

    $display("[TB] single-word read, back-to-back");
    exp_busy_a.push_back(8); exp_addr_a.push_back(32'h10); exp_data_a.push_back(32'h1234);
    applyStimulus(0, 0, 2'b10, 32'h10, 16'h0, 8'd1);
    recordTrace(0, 10);
    checkOutput("rd_busy", busy_m, 32'hFF);
    checkOutput("rd_oe", oe_m, 32'h3C);
    checkOutput("rd_load", load_m, 32'h40);
    checkOutput("rd_doe", doe_m, 32'h0);
    checkOutput("rd_latch", latch_m, 32'h3);
    checkOutput("rd_data_hold", 32'(bus_a.DATA_IN), 32'h1234);

    $display("[TB] auto-load burst with address wrap");
    exp_busy_a.push_back(20);
    exp_addr_a.push_back(32'h7FFFFF); exp_addr_a.push_back(32'h0); exp_addr_a.push_back(32'h1);
    exp_data_a.push_back(32'hFFFF); exp_data_a.push_back(32'h0); exp_data_a.push_back(32'h1);
    wr_before = writes_a;
    applyStimulus(0, 1, 2'b10, 32'h7FFFFF, 16'h0, 8'd3);
    fork
      recordTrace(0, 22);
      begin
        repeat (5) @(negedge clk);
        bus_a.OP = 2'b01; bus_a.EXECUTE = 1'b1; bus_a.AL_EXECUTE = 1'b1;
        @(negedge clk);
        bus_a.EXECUTE = 1'b0; bus_a.AL_EXECUTE = 1'b0;
      end
    join
    checkOutput("burst_busy", busy_m, 32'hFFFFF);
    checkOutput("burst_load", load_m, 32'h41040);
    checkOutput("burst_latch", latch_m, 32'h30C3);
    checkOutput("burst_oe", oe_m, 32'h3CF3C);
    checkOutput("burst_no_write", 32'(writes_a - wr_before), 32'd0);
    bus_a.AUTO_LOAD_ENA = 1'b0;

    $display("[TB] no-op and collision");
    applyStimulus(0, 0, 2'b11, 32'h20, 16'h0, 8'd1);
    recordTrace(0, 4);
    checkOutput("noop_busy", busy_m, 32'h0);
    checkOutput("noop_cs", cs_m, 32'h0);
    exp_busy_a.push_back(8); exp_addr_a.push_back(32'h200);
    exp_waddr_a.push_back(32'h200); exp_wdata_a.push_back(32'h5555);
    wr_before = writes_a;
    applyStimulus(0, 0, 2'b01, 32'h200, 16'h5555, 8'd0);
    fork
      recordTrace(0, 10);
      begin
        repeat (3) @(negedge clk);
        bus_a.ADDR = 23'h300; bus_a.EXECUTE = 1'b1;
        @(negedge clk);
        bus_a.EXECUTE = 1'b0;
      end
    join
    checkOutput("coll_busy", busy_m, 32'hFF);
    checkOutput("coll_we", we_m, 32'h1C);
    checkOutput("coll_write_count", 32'(writes_a - wr_before), 32'd1);

    $display("[TB] reset during burst read");
    exp_busy_a.push_back(4); exp_addr_a.push_back(32'h40);
    applyStimulus(0, 0, 2'b10, 32'h40, 16'h0, 8'd4);
    repeat (4) @(negedge clk);
    checkOutput("rst_in_access", 32'(bus_a.FOE_B), 32'd0);
    rst_a = 1'b1;
    @(negedge clk);
    checkOutput("rst_ctrl", 32'({bus_a.BUSY, bus_a.LOAD_DATA, bus_a.FLASH_D_OE, bus_a.FCS_B,
                                 bus_a.FOE_B, bus_a.FWE_B, bus_a.FLATCH_B}), 32'h0F);
    checkOutput("rst_flash_a", 32'(bus_a.FLASH_A), 32'h0);
    checkOutput("rst_data_in", 32'(bus_a.DATA_IN), 32'h0);
    rst_a = 1'b0;
    exp_busy_a.push_back(8); exp_addr_a.push_back(32'h10); exp_data_a.push_back(32'h1234);
    applyStimulus(0, 0, 2'b10, 32'h10, 16'h0, 8'd1);
    waitIdle(0);

    $display("[TB] minimum timing, 26-bit address");
    exp_busy_b.push_back(4);
    applyStimulus(1, 0, 2'b01, 32'h3FFFFFF, 16'hBEEF, 8'd0);
    recordTrace(1, 5);
    checkOutput("b_wr_busy", busy_m, 32'hF);
    checkOutput("b_wr_latch", latch_m, 32'h1);
    checkOutput("b_wr_we", we_m, 32'h2);
    checkOutput("b_wr_doe", doe_m, 32'h7);
    exp_busy_b.push_back(3); exp_data_b.push_back(32'h0010);
    applyStimulus(1, 0, 2'b10, 32'h2000010, 16'h0, 8'd0);
    recordTrace(1, 4);
    checkOutput("b_rd_busy", busy_m, 32'h7);
    checkOutput("b_rd_oe", oe_m, 32'h2);
    checkOutput("b_rd_load", load_m, 32'h4);
    exp_busy_b.push_back(5); exp_data_b.push_back(32'hFFFF); exp_data_b.push_back(32'h0);
    applyStimulus(1, 0, 2'b10, 32'h3FFFFFF, 16'h0, 8'd2);
    waitIdle(1);

    repeat (3) @(negedge clk);
    checkOutput("left_data_a", 32'(exp_data_a.size()), 32'd0);
    checkOutput("left_busy_a", 32'(exp_busy_a.size()), 32'd0);
    checkOutput("left_addr_a", 32'(exp_addr_a.size()), 32'd0);
    checkOutput("left_write_a", 32'(exp_waddr_a.size()), 32'd0);
    checkOutput("left_data_b", 32'(exp_data_b.size()), 32'd0);
    checkOutput("left_busy_b", 32'(exp_busy_b.size()), 32'd0);
    checkOutput("bus_rule_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
